// File: rtl/instruction_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_controller
//  Description : Owns the fetch PC and drives a synchronous instruction
//                memory. Buffers {pc, instruction} pairs in a small FIFO for
//                the decode stage. Handles branch redirects by flushing the
//                FIFO and killing the in-flight read. A misaligned redirect
//                halts fetching and raises a sticky fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] instructionAddress,
    output logic        imemReadEnable,
    input  logic [31:0] instruction,
    input  logic        branchTaken,
    input  logic [63:0] branchTarget,
    input  logic        decodeReady,
    output logic        instrValid,
    output logic [31:0] instrOut,
    output logic [63:0] pcOut,
    output logic        fetchFault,
    output logic [31:0] fetchedCount
);

    // Pointer width covers DEPTH entries; the count needs to reach DEPTH and
    // carries one extra bit so the occupancy sum (count + inflight) cannot
    // overflow before it is compared against DEPTH.
    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = $clog2(DEPTH + 1) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;

    logic [63:0]      r_pc;
    logic             r_inflight;
    logic [63:0]      r_inflight_pc;

    logic [63:0]      r_fifo_pc    [DEPTH];
    logic [31:0]      r_fifo_instr [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             r_fault;
    logic [31:0]      r_fetched;

    logic             w_misaligned;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_redirect;
    logic             w_issue;
    logic [CNT_W-1:0] w_occupancy;

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_misaligned = (branchTarget[1:0] != 2'b00);
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid & decodeReady;
    // Returning read data is dropped when a redirect kills it this cycle.
    assign w_push       = r_inflight & ~w_redirect;

    // State register: RUN after reset, HALT is absorbing until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: only a misaligned redirect taken in RUN leaves RUN.
    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_RUN) && branchTaken && w_misaligned) begin
            w_state_next = ST_HALT;
        end
    end

    // FSM outputs: redirect and issue decisions. Issue reserves a FIFO slot
    // for the read already in flight so the buffer can never overflow.
    always_comb begin
        w_redirect  = 1'b0;
        w_issue     = 1'b0;
        w_occupancy = r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
        if ((r_state == ST_RUN) && !reset) begin
            w_redirect = branchTaken;
            w_issue    = !branchTaken && (w_occupancy < DEPTH_CNT);
        end
    end

    // PC and in-flight tracking; a redirect kills the outstanding read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (w_redirect) begin
            r_inflight <= 1'b0;
            if (!w_misaligned) begin
                r_pc <= branchTarget;
            end
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + PC_STEP;
            end
        end
    end

    // FIFO storage; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
            r_fifo_instr[r_wr_ptr] <= instruction;
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything.
    always_ff @(posedge clk) begin
        if (reset || w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Sticky fault and accepted-instruction counter; a pop in a redirect
    // cycle still counts because decode did take the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault   <= 1'b0;
            r_fetched <= '0;
        end else begin
            if (w_pop) begin
                r_fetched <= r_fetched + 32'd1;
            end
            if (w_redirect && w_misaligned) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign instructionAddress = r_pc;
    assign imemReadEnable     = w_issue;
    assign instrValid         = w_valid;
    assign instrOut           = w_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign pcOut              = w_valid ? r_fifo_pc[r_rd_ptr] : 64'h0;
    assign fetchFault         = r_fault;
    assign fetchedCount       = r_fetched;

endmodule
`default_nettype wire
